// File: rtl/div_seq_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_seq_param : iterative radix-2 restoring divider, signed/unsigned      |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module div_seq_param #(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             rfd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dd_q, dd_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             smode;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_src;

  always_comb begin
    smode   = sign_mode & (SIGNED_EN != 0);
    // Partial remainder stays below the divisor, so WIDTH bits hold it; the
    // shifted trial value needs one extra bit, and when it is >= divisor the
    // difference fits back into WIDTH bits.
    shifted = {prem_q, dd_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dv_q});
    diff    = shifted[WIDTH-1:0] - dv_q;
    rem_src = zero_q ? dd_q : prem_q;

    state_d     = state_q;
    dd_d        = dd_q;
    dv_d        = dv_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_quo_d = smode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = smode & dividend[WIDTH-1];
          dd_d      = (smode & dividend[WIDTH-1]) ? -dividend : dividend;
          dv_d      = (smode & divisor[WIDTH-1])  ? -divisor  : divisor;
          prem_d    = '0;
          cnt_d     = '0;
          zero_d    = (divisor == '0);
          state_d   = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        // Dividend register doubles as the quotient shift register.
        prem_d = ge ? diff : shifted[WIDTH-1:0];
        dd_d   = {dd_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // On divide-by-zero dd_q still holds |dividend|; re-applying the sign
        // returns the dividend exactly as supplied.
        quotient_d  = zero_q ? '1 : (neg_quo_q ? -dd_q : dd_q);
        remainder_d = neg_rem_q ? -rem_src : rem_src;
        dbz_d       = zero_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dd_q        <= '0;
      dv_q        <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dd_q        <= dd_d;
      dv_q        <= dv_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign rfd         = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_seq_param : scoreboard bench for div_seq_param (WIDTH=16)          |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign_mode = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        rfd, busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  div_seq_param #(.WIDTH(16), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign_mode(sign_mode),
    .dividend(dividend), .divisor(divisor), .rfd(rfd), .busy(busy),
    .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t last = '{q: 16'h0, r: 16'h0, dbz: 1'b0, at: 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each done, otherwise checks results are held.
  always @(negedge clk) begin
    if (!rst_n) begin
      last = '{q: 16'h0, r: 16'h0, dbz: 1'b0, at: 0};
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {16'h0, quotient}, {16'h0, e.q});
        check("remainder", {16'h0, remainder}, {16'h0, e.r});
        check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
        check("done_cycle", cyc, e.at);
        last = e;
      end
    end else begin
      check("hold_q", {16'h0, quotient}, {16'h0, last.q});
      check("hold_r", {16'h0, remainder}, {16'h0, last.r});
      check("hold_dbz", {31'h0, div_by_zero}, {31'h0, last.dbz});
    end
  end

  // Issue one op at a negedge; lat is the number of edges from accept to done.
  task automatic do_op(input logic [15:0] dd, input logic [15:0] dv, input logic sm,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                       input int lat);
    exp_t e;
    int   t;
    t = 0;
    while (!rfd && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rfd) check("rfd_timeout", 32'd0, 32'd1);
    dividend  = dd;
    divisor   = dv;
    sign_mode = sm;
    start     = 1'b1;
    e = '{q: eq, r: er, dbz: edbz, at: cyc + 1 + lat};
    sb.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    dividend  = 16'($urandom);
    divisor   = 16'($urandom);
    sign_mode = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int bc;
    int e0;
    repeat (3) @(negedge clk);
    check("rst_q", {16'h0, quotient}, 32'h0);
    check("rst_r", {16'h0, remainder}, 32'h0);
    check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rfd", {31'h0, rfd}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 100/7 with busy-length measurement.
    do_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 17);
    bc = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    check("busy_cycles", bc, 32'd17);
    drain();

    // Signed truncation and remainder sign; back-to-back issue in done cycle.
    do_op(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17);
    do_op(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 17);
    do_op(16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 17);
    do_op(16'd60000, 16'd255, 1'b0, 16'd235, 16'd75, 1'b0, 17);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 17);

    // Divide by zero, then a normal op.
    do_op(16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1, 1);
    do_op(16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, 17);
    do_op(16'hFFFB, 16'd0, 1'b1, 16'hFFFF, 16'hFFFB, 1'b1, 1);

    // Signed overflow and the same operands unsigned.
    do_op(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 17);
    do_op(16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 17);
    drain();

    // start held high: accepts exactly 18 edges apart.
    dividend  = 16'd20;
    divisor   = 16'd3;
    sign_mode = 1'b0;
    start     = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{q: 16'd6, r: 16'd2, dbz: 1'b0, at: e0 + 17});
    sb.push_back('{q: 16'd6, r: 16'd2, dbz: 1'b0, at: e0 + 18 + 17});
    repeat (19) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of 0xFFFF/1: immediate clear, no done.
    dividend  = 16'hFFFF;
    divisor   = 16'h0001;
    sign_mode = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q", {16'h0, quotient}, 32'h0);
    check("mid_rst_r", {16'h0, remainder}, 32'h0);
    check("mid_rst_dbz", {31'h0, div_by_zero}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rfd", {31'h0, rfd}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    do_op(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 17);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
